// File: rtl/lcd_rx_pkg.sv
// Shared types and constants for the HD44780 4-bit bus receiver.
// The state enum, the instruction encodings the receiver reacts to,
// and the blank character used to initialise the shadow display memory.
package lcd_rx_pkg;

    typedef enum logic [1:0] {
        BOOT8 = 2'd0,
        HI    = 2'd1,
        LO    = 2'd2
    } rx_state_t;

    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_HOME       = 8'h02;
    localparam logic [7:0] CMD_SET_DDRAM  = 8'h80;
    localparam logic [3:0] FS_NIBBLE_8BIT = 4'h3;
    localparam logic [3:0] FS_NIBBLE_4BIT = 4'h2;
    localparam logic [7:0] BLANK_CHAR     = 8'h20;

    // A function-set instruction with DL=1 puts the panel back into 8-bit boot mode.
    function automatic logic is_func_set_8bit(input logic rs, input logic [7:0] value);
        return (rs == 1'b0) && (value[7:4] == FS_NIBBLE_8BIT);
    endfunction

    // Return-home is encoded as 0000_001x, so bit 0 is a don't-care.
    function automatic logic is_home(input logic [7:0] value);
        return value[7:1] == CMD_HOME[7:1];
    endfunction

endpackage

// File: rtl/lcd_rx_fifo.sv
// Small synchronous FIFO holding decoded {rs, data} entries.
// The head entry is read straight out of the storage flops, so it only
// moves when the read pointer advances or when an empty FIFO is written.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module lcd_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Storage: cleared on reset so the head reads zero while the FIFO is empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_hd44780_rx.sv
// Receiver for the 4-bit HD44780 LCD bus.
// Synchronizes RS/E/D, detects E falling edges, follows the 8-bit boot to
// 4-bit handshake, pairs nibbles into bytes and queues them in a FIFO.
// Optional feature macro: LCD_RX_DDRAM_EN builds a 32x8 shadow DDRAM with cursor.
module lcd_hd44780_rx
    import lcd_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rs,
    input  logic       lcd_e,
    input  logic [3:0] lcd_d,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_rs,
    output logic       mode_4bit,
    output logic       overflow,
    output logic       frame_err,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [4:0] cursor
);

    // Bus bit order inside the synchronizer: {rs, e, d[3:0]}
    logic [5:0] sync_q [SYNC_STAGES];
    logic       e_dly;
    logic       s_rs;
    logic       s_e;
    logic [3:0] s_d;
    logic       strobe;

    rx_state_t  state;
    rx_state_t  next_state;
    logic [3:0] hi_nib;
    logic       hi_rs;

    logic       load_hi;
    logic       decode_valid;
    logic [7:0] decode_byte;
    logic       decode_rs;
    logic       frame_set;

    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic [8:0] fifo_head;

    // Multi-flop synchronizer on all bus lines, plus one extra E flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            e_dly <= 1'b0;
        end else begin
            sync_q[0] <= {lcd_rs, lcd_e, lcd_d};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            e_dly <= s_e;
        end
    end

    assign s_rs   = sync_q[SYNC_STAGES-1][5];
    assign s_e    = sync_q[SYNC_STAGES-1][4];
    assign s_d    = sync_q[SYNC_STAGES-1][3:0];
    assign strobe = e_dly && !s_e;

    // State register for the nibble-pairing state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT8;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: boot handshake, nibble pairing and fallback to 8-bit mode.
    always_comb begin
        next_state = state;
        case (state)
            BOOT8: begin
                if (strobe && !s_rs && (s_d == FS_NIBBLE_4BIT)) begin
                    next_state = HI;
                end
            end
            HI: begin
                if (strobe) begin
                    next_state = LO;
                end
            end
            LO: begin
                if (strobe && (s_rs == hi_rs)) begin
                    if (is_func_set_8bit(hi_rs, {hi_nib, s_d})) begin
                        next_state = BOOT8;
                    end else begin
                        next_state = HI;
                    end
                end
            end
            default: next_state = BOOT8;
        endcase
    end

    // Output logic: which strobes decode a byte, which load the high nibble, which flag a framing error.
    always_comb begin
        load_hi      = 1'b0;
        decode_valid = 1'b0;
        decode_byte  = 8'h00;
        decode_rs    = 1'b0;
        frame_set    = 1'b0;
        case (state)
            BOOT8: begin
                decode_valid = strobe;
                decode_byte  = {s_d, 4'h0};
                decode_rs    = s_rs;
            end
            HI: begin
                load_hi = strobe;
            end
            LO: begin
                if (strobe) begin
                    if (s_rs == hi_rs) begin
                        decode_valid = 1'b1;
                        decode_byte  = {hi_nib, s_d};
                        decode_rs    = hi_rs;
                    end else begin
                        frame_set = 1'b1;
                        load_hi   = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // High-nibble latch, also reloaded when a framing error restarts the pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_nib <= 4'h0;
            hi_rs  <= 1'b0;
        end else if (load_hi) begin
            hi_nib <= s_d;
            hi_rs  <= s_rs;
        end
    end

    assign mode_4bit = (state != BOOT8);

    assign pop = out_valid && out_ready;

    lcd_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (decode_valid),
        .push_data ({decode_rs, decode_byte}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_rs    = fifo_head[8];
    assign out_data  = fifo_head[7:0];

    // Sticky error flags; a byte is lost only when the FIFO is full and nothing leaves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (decode_valid && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (frame_set) begin
                frame_err <= 1'b1;
            end
        end
    end

`ifdef LCD_RX_DDRAM_EN
    logic [7:0] ddram [32];
    logic [4:0] cur;

    // Shadow display memory follows the decoded stream regardless of FIFO back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                ddram[i] <= BLANK_CHAR;
            end
            cur <= 5'd0;
        end else if (decode_valid) begin
            if (decode_rs) begin
                ddram[cur] <= decode_byte;
                cur        <= cur + 5'd1;
            end else if (decode_byte == CMD_CLEAR) begin
                for (int i = 0; i < 32; i++) begin
                    ddram[i] <= BLANK_CHAR;
                end
                cur <= 5'd0;
            end else if (is_home(decode_byte)) begin
                cur <= 5'd0;
            end else if ((decode_byte & CMD_SET_DDRAM) != 8'h00) begin
                cur <= {decode_byte[6], decode_byte[3:0]};
            end
        end
    end

    assign rd_data = ddram[rd_addr];
    assign cursor  = cur;
`else
    logic unused_rd_addr;

    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = 8'h00;
    assign cursor         = 5'd0;
`endif

endmodule
